// File: rtl/fetch_unit.sv
// Instruction fetch stage: samples the PC, issues one imem read at a time,
// and hands address-tagged instructions to decode through a 2-entry queue.
module fetch_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_inc,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic [1:0]        dbg_state
);

    // Handshakes: imem_req/imem_addr stay put until imem_ack is sampled high;
    // a decode transfer happens on every edge where instr_valid & instr_ready,
    // and the head entry never changes while instr_valid=1 and instr_ready=0.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic                w_req_next;

    logic                r_req;
    logic                r_pc_inc;
    logic [ADDR_W-1:0]   r_addr;

    // Entry 0 is always the head, so the decode outputs come straight off flops.
    logic                r_v0;
    logic                r_v1;
    logic [DATA_W-1:0]   r_d0;
    logic [DATA_W-1:0]   r_d1;
    logic [ADDR_W-1:0]   r_p0;
    logic [ADDR_W-1:0]   r_p1;

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_push       = 1'b0;
        w_req_next   = r_req;
        case (r_state)
            S_IDLE: begin
                if (!flush && !r_v1) begin
                    w_issue      = 1'b1;
                    w_req_next   = 1'b1;
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    w_push       = !flush;
                    w_req_next   = 1'b0;
                    w_state_next = S_IDLE;
                end else if (flush) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_ack) begin
                    w_req_next   = 1'b0;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_req_next   = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
        w_pop = r_v0 && instr_ready && !flush;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_req    <= 1'b0;
            r_pc_inc <= 1'b0;
            r_addr   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_req    <= w_req_next;
            r_pc_inc <= w_issue;
            if (w_issue) begin
                r_addr <= pc_in;
            end
        end
    end

    // r_addr doubles as the tag of the outstanding request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
            r_d0 <= '0;
            r_d1 <= '0;
            r_p0 <= '0;
            r_p1 <= '0;
        end else if (flush) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b11: begin
                    if (r_v1) begin
                        r_d0 <= r_d1;
                        r_p0 <= r_p1;
                        r_d1 <= imem_rdata;
                        r_p1 <= r_addr;
                    end else begin
                        r_d0 <= imem_rdata;
                        r_p0 <= r_addr;
                    end
                end
                2'b01: begin
                    r_d0 <= r_d1;
                    r_p0 <= r_p1;
                    r_v0 <= r_v1;
                    r_v1 <= 1'b0;
                end
                2'b10: begin
                    if (!r_v0) begin
                        r_d0 <= imem_rdata;
                        r_p0 <= r_addr;
                        r_v0 <= 1'b1;
                    end else begin
                        r_d1 <= imem_rdata;
                        r_p1 <= r_addr;
                        r_v1 <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign pc_inc      = r_pc_inc;
    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instr_valid = r_v0;
    assign instr_data  = r_d0;
    assign instr_pc    = r_p0;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle model with an expected-entry queue, a variable
// latency memory responder, directed scenarios, then a random phase.
module tb_fetch_unit;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc_in;
    logic          pc_inc;
    logic          flush;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [DW-1:0] imem_rdata;
    logic          instr_valid;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .pc_inc      (pc_inc),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .dbg_state   (dbg_state)
    );

    logic [AW+DW-1:0] exp_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;

    logic          m_out;
    logic          m_keep;
    logic [AW-1:0] m_pc;
    logic          m_rst;
    logic          m_iss;

    logic          mem_en;
    int            mem_lat;
    int            mem_cnt;
    logic          fix_en;
    logic [DW-1:0] fix_data;
    logic          pc_follow;
    int            n_inc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        int   cnt0;
        logic iss;
        cnt0 = exp_q.size();
        iss  = !reset && !m_out && !flush && (cnt0 < 2);
        if (reset) begin
            exp_q.delete();
            m_out  = 1'b0;
            m_keep = 1'b0;
        end else begin
            if (flush) begin
                exp_q.delete();
                m_keep = 1'b0;
            end else if (cnt0 > 0 && instr_ready) begin
                void'(exp_q.pop_front());
            end
            if (m_out && imem_ack) begin
                if (m_keep) exp_q.push_back({m_pc, imem_rdata});
                m_out = 1'b0;
            end
            if (iss) begin
                m_out  = 1'b1;
                m_keep = 1'b1;
                m_pc   = pc_in;
            end
        end
        m_rst = reset;
        m_iss = iss;

        @(posedge clk);
        #1;

        if (m_rst) begin
            check("rst_req",   imem_req,    0);
            check("rst_addr",  imem_addr,   0);
            check("rst_inc",   pc_inc,      0);
            check("rst_valid", instr_valid, 0);
            check("rst_data",  instr_data,  0);
            check("rst_pc",    instr_pc,    0);
        end else begin
            check("req",    imem_req, m_out);
            check("pc_inc", pc_inc,   m_iss);
            if (m_out) check("addr", imem_addr, m_pc);
            check("valid", instr_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check("head_data", instr_data, exp_q[0][DW-1:0]);
                check("head_pc",   instr_pc,   exp_q[0][AW+DW-1:DW]);
            end
        end
        if (pc_inc) n_inc++;

        // memory responder
        if (imem_req && mem_en && mem_cnt >= mem_lat) begin
            imem_ack   = 1'b1;
            imem_rdata = fix_en ? fix_data : DW'($urandom);
        end else begin
            imem_ack = 1'b0;
        end
        if (imem_req) mem_cnt++;
        else          mem_cnt = 0;

        if (pc_follow && pc_inc) pc_in = pc_in + 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        n_inc = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; pc_in = '0; imem_ack = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0;
        m_out = 1'b0; m_keep = 1'b0; m_pc = '0; m_rst = 1'b0; m_iss = 1'b0;
        mem_en = 1'b1; mem_lat = 3; mem_cnt = 0; fix_en = 1'b1; fix_data = 16'hABCD;
        pc_follow = 1'b0; n_inc = 0;

        // reset values and first fetch
        do_reset();
        for (int i = 0; i < 20 && !instr_valid; i++) tick();
        check("s1_valid", instr_valid, 1);
        check("s1_data",  instr_data,  16'hABCD);
        check("s1_pc",    instr_pc,    16'h0000);
        check("s1_inc",   n_inc,       1);

        // backpressure
        fix_en = 1'b0; mem_lat = 0; instr_ready = 1'b0; pc_follow = 1'b1; pc_in = 16'h0010;
        do_reset();
        repeat (12) tick();
        check("bp_inc",  n_inc,    2);
        check("bp_req",  imem_req, 0);
        check("bp_head", instr_pc, 16'h0010);
        instr_ready = 1'b1;
        tick();
        check("bp_next", instr_pc, 16'h0011);
        for (int i = 0; i < 10 && !imem_req; i++) tick();
        check("bp_addr3", imem_addr, 16'h0012);
        repeat (6) tick();

        // flush during WAIT
        mem_en = 1'b0; pc_in = 16'h0005; instr_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 5 && !imem_req; i++) tick();
        check("fw_addr", imem_addr, 16'h0005);
        flush = 1'b1; pc_in = 16'h0100;
        tick();
        flush = 1'b0;
        tick();
        check("fw_req_held", imem_req,  1);
        check("fw_drain",    dbg_state, 2);
        check("fw_no_inc",   pc_inc,    0);
        mem_en = 1'b1; mem_lat = 0;
        for (int i = 0; i < 20 && !instr_valid; i++) tick();
        check("fw_first_pc", instr_pc, 16'h0100);

        // flush coincident with ack
        mem_en = 1'b0; pc_in = 16'h0300;
        do_reset();
        for (int i = 0; i < 5 && !imem_req; i++) tick();
        mem_en = 1'b1; mem_lat = 0;
        tick();
        check("fa_ack", imem_ack, 1);
        flush = 1'b1; pc_in = 16'h0400;
        tick();
        flush = 1'b0; mem_en = 1'b0;
        check("fa_valid", instr_valid, 0);
        check("fa_state", dbg_state,   0);
        check("fa_req",   imem_req,    0);

        // same-cycle push and pop
        mem_en = 1'b1; mem_lat = 2; instr_ready = 1'b0; pc_in = 16'h0500;
        do_reset();
        for (int i = 0; i < 30 && !(imem_ack && instr_valid); i++) tick();
        check("pp_setup", instr_pc, 16'h0500);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("pp_valid", instr_valid, 1);
        check("pp_pc",    instr_pc,    16'h0501);

        // reset mid-operation
        mem_en = 1'b1; mem_lat = 0; instr_ready = 1'b0; pc_in = 16'h0600;
        do_reset();
        for (int i = 0; i < 20 && !instr_valid; i++) tick();
        mem_en = 1'b0;
        tick();
        check("rm_wait", dbg_state, 1);
        reset = 1'b1; pc_in = 16'h0700;
        tick();
        reset = 1'b0; mem_en = 1'b1; n_inc = 0;
        check("rm_req",   imem_req,    0);
        check("rm_valid", instr_valid, 0);
        check("rm_inc",   pc_inc,      0);
        for (int i = 0; i < 5 && !imem_req; i++) tick();
        check("rm_addr", imem_addr, 16'h0700);

        // random traffic, starting near PC wrap-around
        pc_in = 16'hFFFE;
        for (int i = 0; i < 400; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            if (flush) pc_in = AW'($urandom);
            if (!imem_req) mem_lat = $urandom_range(0, 3);
            tick();
        end
        flush = 1'b0; instr_ready = 1'b1;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
